// File: rtl/parity_stream_acc.sv
// parity_stream_acc: running XOR parity per packet over a valid/ready stream
//
// Accumulates the XOR of every bit of every accepted WIDTH-bit word in a packet.
// When the word carrying in_last is accepted, it registers one result:
//   - parity, inverted when ODD=1
//   - word count, saturated at MAX_WORDS
//   - overflow flag
// The result is held on the output handshake until the sink takes it.
//
// Optional compare feature, macro PARITY_STREAM_CHECK_EN:
//   - adds input in_exp_parity, sampled with the last word
//   - adds output out_err, set when the computed parity differs from in_exp_parity
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   in_valid     in   source has a word
//   in_ready     out  word accepted this cycle (low while a result is held)
//   in_data      in   WIDTH-bit data word
//   in_last      in   final word of the packet
//   out_valid    out  packet result available
//   out_ready    in   sink takes the result
//   out_parity   out  packet parity (even, or odd when ODD=1)
//   out_count    out  words in the packet, saturated at MAX_WORDS
//   out_overflow out  packet exceeded MAX_WORDS words
//   in_exp_parity in  expected parity (PARITY_STREAM_CHECK_EN only)
//   out_err      out  parity compare error (PARITY_STREAM_CHECK_EN only)
module parity_stream_acc #(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    parameter  int ODD       = 0,
    localparam int CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef PARITY_STREAM_CHECK_EN
    input  logic             in_exp_parity,
    output logic             out_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic            parity_q, parity_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            in_fire, out_fire, cap, cnt_sat, acc_n, ovf_n;
    logic [CW-1:0]   cnt_n;

    // Results are only ever held in HOLD, where in_ready is low, so a take
    // and an accept can never happen on the same edge.
    assign in_ready = (state_q != HOLD);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;
    assign cap      = in_fire && in_last;

    // Values after folding in the current word.
    assign cnt_sat  = (cnt_q == CW'(MAX_WORDS));
    assign acc_n    = acc_q ^ (^in_data);
    assign cnt_n    = cnt_sat ? cnt_q : cnt_q + CW'(1);
    assign ovf_n    = ovf_q | cnt_sat;

    always_comb begin
        state_d    = out_fire ? IDLE : cap ? HOLD : in_fire ? ACCUM : state_q;
        acc_d      = out_fire ? 1'b0 : in_fire ? acc_n : acc_q;
        cnt_d      = out_fire ? '0 : in_fire ? cnt_n : cnt_q;
        ovf_d      = out_fire ? 1'b0 : in_fire ? ovf_n : ovf_q;
        valid_d    = cap | (valid_q & ~out_ready);
        parity_d   = cap ? acc_n ^ 1'(ODD) : parity_q;
        count_d    = cap ? cnt_n : count_q;
        overflow_d = cap ? ovf_n : overflow_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            parity_q   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            parity_q   <= parity_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_parity   = parity_q;
    assign out_count    = count_q;
    assign out_overflow = overflow_q;

`ifdef PARITY_STREAM_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = cap ? ((acc_n ^ 1'(ODD)) != in_exp_parity) : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_parity_stream_acc.sv
// tb_parity_stream_acc: directed self-checking bench for parity_stream_acc
//
// Three instances share one input stream:
//   - u_even: defaults (even parity, MAX_WORDS=16)
//   - u_odd:  odd parity
//   - u_sat:  MAX_WORDS=4, to reach count saturation and overflow
// Expected values are hand-computed constants.
module tb_parity_stream_acc;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_last, out_ready, in_exp_parity;
    logic [7:0] in_data;

    logic       e_rdy, e_vld, e_par, e_ovf;
    logic [4:0] e_cnt;
    logic       o_rdy, o_vld, o_par, o_ovf;
    logic [4:0] o_cnt;
    logic       m_rdy, m_vld, m_par, m_ovf;
    logic [2:0] m_cnt;
`ifdef PARITY_STREAM_CHECK_EN
    logic       e_err, o_err, m_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_stream_acc #(.WIDTH(8), .MAX_WORDS(16), .ODD(0)) u_even (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_rdy),
        .in_data(in_data), .in_last(in_last),
`ifdef PARITY_STREAM_CHECK_EN
        .in_exp_parity(in_exp_parity), .out_err(e_err),
`endif
        .out_valid(e_vld), .out_ready(out_ready), .out_parity(e_par),
        .out_count(e_cnt), .out_overflow(e_ovf)
    );

    parity_stream_acc #(.WIDTH(8), .MAX_WORDS(16), .ODD(1)) u_odd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_rdy),
        .in_data(in_data), .in_last(in_last),
`ifdef PARITY_STREAM_CHECK_EN
        .in_exp_parity(in_exp_parity), .out_err(o_err),
`endif
        .out_valid(o_vld), .out_ready(out_ready), .out_parity(o_par),
        .out_count(o_cnt), .out_overflow(o_ovf)
    );

    parity_stream_acc #(.WIDTH(8), .MAX_WORDS(4), .ODD(0)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_rdy),
        .in_data(in_data), .in_last(in_last),
`ifdef PARITY_STREAM_CHECK_EN
        .in_exp_parity(in_exp_parity), .out_err(m_err),
`endif
        .out_valid(m_vld), .out_ready(out_ready), .out_parity(m_par),
        .out_count(m_cnt), .out_overflow(m_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for one edge; afterwards drive junk with in_valid low.
    task automatic send(input logic [7:0] d, input logic l, input logic e = 1'b0);
        chk("in_ready_before_word", {29'd0, e_rdy, o_rdy, m_rdy}, 32'h7);
        in_valid      = 1'b1;
        in_data       = d;
        in_last       = l;
        in_exp_parity = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_last  = 1'b1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_take", {29'd0, e_vld, o_vld, m_vld}, 32'h0);
        chk("ready_after_take", {29'd0, e_rdy, o_rdy, m_rdy}, 32'h7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        in_exp_parity = 1'b0;
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", e_vld, 0);
        chk("rst_parity", e_par, 0);
        chk("rst_count", e_cnt, 0);
        chk("rst_overflow", e_ovf, 0);
        chk("rst_ready", e_rdy, 1);

        // Single word A5: four ones, even parity 0.
        send(8'hA5, 1'b1);
        chk("single_valid", e_vld, 1);
        chk("single_parity", e_par, 0);
        chk("single_count", e_cnt, 1);
        chk("single_overflow", e_ovf, 0);
        chk("single_ready", e_rdy, 0);
        chk("single_odd_parity", o_par, 1);
        take();

        // 01,03,07 with an idle gap: six ones, parity 0.
        send(8'h01, 1'b0);
        @(posedge clk);
        #1;
        send(8'h03, 1'b0);
        send(8'h07, 1'b1);
        chk("three_parity", e_par, 0);
        chk("three_count", e_cnt, 3);
        chk("three_odd_parity", o_par, 1);
        chk("three_sat_count", m_cnt, 3);
        chk("three_sat_overflow", m_ovf, 0);

        // Backpressure: result must hold.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", e_vld, 1);
            chk("bp_parity", e_par, 0);
            chk("bp_count", e_cnt, 3);
            chk("bp_ready", e_rdy, 0);
            chk("bp_odd_parity", o_par, 1);
        end
        take();
        chk("after_take_count", e_cnt, 3);
        chk("after_take_odd_parity", o_par, 1);

        // Six words of 01: u_sat saturates at 4 and flags overflow.
        for (int i = 0; i < 6; i++) send(8'h01, i == 5);
        chk("ovf_sat_count", m_cnt, 4);
        chk("ovf_sat_overflow", m_ovf, 1);
        chk("ovf_sat_parity", m_par, 0);
        chk("ovf_even_count", e_cnt, 6);
        chk("ovf_even_overflow", e_ovf, 0);
        take();
        send(8'h01, 1'b1);
        chk("post_ovf_overflow", m_ovf, 0);
        chk("post_ovf_count", m_cnt, 1);
        chk("post_ovf_parity", m_par, 1);
        take();

        // Asynchronous reset mid-packet, between edges.
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", e_vld, 0);
        chk("arst_parity", e_par, 0);
        chk("arst_count", e_cnt, 0);
        chk("arst_sat_count", m_cnt, 0);
        chk("arst_odd_parity", o_par, 0);
        chk("arst_ready", e_rdy, 1);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'h80, 1'b1);
        chk("fresh_parity", e_par, 1);
        chk("fresh_count", e_cnt, 1);
        chk("fresh_sat_overflow", m_ovf, 0);
        take();

`ifdef PARITY_STREAM_CHECK_EN
        // 0F,01: five ones, even parity 1.
        send(8'h0F, 1'b0, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        chk("chk_parity", e_par, 1);
        chk("chk_err_exp0", e_err, 1);
        chk("chk_odd_err_exp0", o_err, 0);
        take();
        send(8'h0F, 1'b0, 1'b1);
        send(8'h01, 1'b1, 1'b1);
        chk("chk_err_exp1", e_err, 0);
        chk("chk_odd_err_exp1", o_err, 1);
        take();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
